// File: rtl/alu_mc.sv
// Multi-cycle ALU for the MIPS datapath: single-step ops finish in one cycle,
// MUL (shift-add) and DIV (restoring) iterate once per bit. Results and flags are registered together.
module alu_mc #(
  parameter int WIDTH      = 8,
  parameter bit CMP_SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_opc,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_dz,
  output logic             halted
);

  // Both handshakes transfer on a rising edge where valid && ready; the producer
  // holds valid and its payload steady until that edge, and ready never depends on valid.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] OP_LDI  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_ADI  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_DIV  = 4'h5;
  localparam logic [3:0] OP_INC  = 4'h6;
  localparam logic [3:0] OP_DEC  = 4'h7;
  localparam logic [3:0] OP_NOR  = 4'h8;
  localparam logic [3:0] OP_NAND = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_COMP = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_CMPJ = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [3:0]       opc_q;
  logic [WIDTH-1:0] opnd;   // multiplicand or divisor
  logic [WIDTH-1:0] acc;    // partial product high half or partial remainder
  logic [WIDTH-1:0] mq;     // multiplier / product low half, or dividend / quotient

  assign in_ready  = rst_n && (state == S_IDLE) && !halted;
  assign out_valid = (state == S_DONE);

  logic [WIDTH-1:0] as_x, as_y, res, res_hi;
  logic [WIDTH:0]   as_r;
  logic             as_sub, as_v, cmp_ge, res_c, res_v, res_dz;

  always_comb begin
    as_x   = alu_a;
    as_y   = alu_b;
    as_sub = 1'b0;
    case (alu_opc)
      OP_SUB:  as_sub = 1'b1;
      OP_INC:  as_y = WIDTH'(1);
      OP_DEC:  begin as_y = WIDTH'(1); as_sub = 1'b1; end
      default: ;
    endcase
    as_r = as_sub ? ({1'b0, as_x} - {1'b0, as_y}) : ({1'b0, as_x} + {1'b0, as_y});
    as_v = as_sub ? ((as_x[MSB] != as_y[MSB]) && (as_r[MSB] != as_x[MSB]))
                  : ((as_x[MSB] == as_y[MSB]) && (as_r[MSB] != as_x[MSB]));
    cmp_ge = CMP_SIGNED ? ($signed(alu_a) >= $signed(alu_b)) : (alu_a >= alu_b);

    res    = '0;
    res_hi = '0;
    res_c  = 1'b0;
    res_v  = 1'b0;
    res_dz = 1'b0;
    case (alu_opc)
      OP_LDI: res = alu_b;
      OP_ADD, OP_ADI, OP_JMP, OP_SUB, OP_INC, OP_DEC: begin
        res   = as_r[MSB:0];
        res_c = as_r[WIDTH];
        res_v = as_v;
      end
      // Only divide-by-zero reaches the single-step path.
      OP_DIV: begin
        res    = '1;
        res_hi = alu_a;
        res_dz = 1'b1;
      end
      OP_NOR:  res = ~(alu_a | alu_b);
      OP_NAND: res = ~(alu_a & alu_b);
      OP_XOR:  res = alu_a ^ alu_b;
      OP_COMP: res = ~alu_b;
      OP_CMPJ: res = {{(WIDTH-1){1'b0}}, cmp_ge};
      default: res = alu_a;
    endcase
  end

  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH-1:0] mul_acc_n, mul_mq_n, div_rem_n, div_q_n;
  logic             div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
    mul_acc_n = mul_sum[WIDTH:1];
    mul_mq_n  = {mul_sum[0], mq[MSB:1]};
    div_sh    = {acc, mq[MSB]};
    div_ge    = (div_sh >= {1'b0, opnd});
    div_rem_n = div_ge ? WIDTH'(div_sh - {1'b0, opnd}) : div_sh[MSB:0];
    div_q_n   = {mq[MSB-1:0], div_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      opc_q      <= '0;
      opnd       <= '0;
      acc        <= '0;
      mq         <= '0;
      alu_out    <= '0;
      alu_out_hi <= '0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
      flag_dz    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid && in_ready) begin
          opc_q <= alu_opc;
          if (alu_opc == OP_MUL) begin
            acc   <= '0;
            mq    <= alu_b;
            opnd  <= alu_a;
            cnt   <= CW'(WIDTH);
            state <= S_MUL;
          end else if (alu_opc == OP_DIV && alu_b != '0) begin
            acc   <= '0;
            mq    <= alu_a;
            opnd  <= alu_b;
            cnt   <= CW'(WIDTH);
            state <= S_DIV;
          end else begin
            alu_out    <= res;
            alu_out_hi <= res_hi;
            flag_z     <= (res == '0);
            flag_c     <= res_c;
            flag_v     <= res_v;
            flag_dz    <= res_dz;
            state      <= S_DONE;
          end
        end
        S_MUL: begin
          acc <= mul_acc_n;
          mq  <= mul_mq_n;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            alu_out    <= mul_mq_n;
            alu_out_hi <= mul_acc_n;
            flag_z     <= (mul_mq_n == '0);
            flag_c     <= (mul_acc_n != '0);
            flag_v     <= 1'b0;
            flag_dz    <= 1'b0;
            state      <= S_DONE;
          end
        end
        S_DIV: begin
          acc <= div_rem_n;
          mq  <= div_q_n;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            alu_out    <= div_q_n;
            alu_out_hi <= div_rem_n;
            flag_z     <= (div_q_n == '0);
            flag_c     <= 1'b0;
            flag_v     <= 1'b0;
            flag_dz    <= 1'b0;
            state      <= S_DONE;
          end
        end
        default: if (out_ready) begin
          state <= S_IDLE;
          if (opc_q == OP_HALT) halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed vector table, randomized ops against an arithmetic model,
// and hand-written reset/hold/halt sequences; a second instance covers WIDTH=16 signed CMPJ.
module tb_alu_mc;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   alu_opc;
  logic [W-1:0] alu_a, alu_b, alu_out, alu_out_hi;
  logic         flag_z, flag_c, flag_v, flag_dz, halted;

  logic         in_valid_w, in_ready_w, out_valid_w, out_ready_w;
  logic [3:0]   alu_opc_w;
  logic [15:0]  alu_a_w, alu_b_w, alu_out_w, alu_out_hi_w;
  logic         flag_z_w, flag_c_w, flag_v_w, flag_dz_w, halted_w;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W), .CMP_SIGNED(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_opc(alu_opc), .alu_a(alu_a), .alu_b(alu_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .alu_out_hi(alu_out_hi),
    .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .flag_dz(flag_dz), .halted(halted)
  );

  alu_mc #(.WIDTH(16), .CMP_SIGNED(1'b1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .alu_opc(alu_opc_w), .alu_a(alu_a_w), .alu_b(alu_b_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w),
    .alu_out(alu_out_w), .alu_out_hi(alu_out_hi_w),
    .flag_z(flag_z_w), .flag_c(flag_c_w), .flag_v(flag_v_w), .flag_dz(flag_dz_w), .halted(halted_w)
  );

  typedef struct {
    logic [7:0] out, hi;
    logic       c, v, z, dz;
    int         lat;
  } exp_t;

  typedef struct {
    logic [3:0] opc;
    logic [7:0] a, b;
    exp_t       e;
    int         hold;
  } vec_t;

  int           n_chk = 0;
  int           n_pass = 0;
  logic [W-1:0] exp_q[$];
  vec_t         tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] opc, input logic [7:0] a, b, out, hi,
                              input logic c, v, z, dz, input int lat, hold);
    vec_t t;
    t.opc = opc; t.a = a; t.b = b; t.hold = hold;
    t.e.out = out; t.e.hi = hi; t.e.c = c; t.e.v = v; t.e.z = z; t.e.dz = dz; t.e.lat = lat;
    return t;
  endfunction

  function automatic int sval(input logic [7:0] x);
    return (x >= 8'd128) ? int'(x) - 256 : int'(x);
  endfunction

  // Reference: plain integer arithmetic, then reduced mod 256.
  function automatic exp_t model(input logic [3:0] opc, input logic [7:0] a, b);
    exp_t e;
    int ua, ub, sa, sb, r, sr;
    ua = int'(a); ub = int'(b); sa = sval(a); sb = sval(b);
    r = 0; sr = 0;
    e.hi = 8'h00; e.c = 1'b0; e.v = 1'b0; e.dz = 1'b0; e.lat = 1;
    case (opc)
      4'h0: r = ub;
      4'h1, 4'h2, 4'hC: begin r = ua + ub; sr = sa + sb; e.c = (r > 255); e.v = (sr > 127 || sr < -128); end
      4'h3: begin r = ua - ub; sr = sa - sb; e.c = (ua < ub); e.v = (sr > 127 || sr < -128); end
      4'h4: begin r = ua * ub; e.hi = 8'(r / 256); e.c = (r >= 256); e.lat = W + 1; end
      4'h5: begin
        if (ub == 0) begin r = 255; e.hi = a; e.dz = 1'b1; end
        else begin r = ua / ub; e.hi = 8'(ua % ub); e.lat = W + 1; end
      end
      4'h6: begin r = ua + 1; sr = sa + 1; e.c = (r > 255); e.v = (sr > 127); end
      4'h7: begin r = ua - 1; sr = sa - 1; e.c = (ua == 0); e.v = (sr < -128); end
      4'h8: r = ~(ua | ub);
      4'h9: r = ~(ua & ub);
      4'hA: r = ua ^ ub;
      4'hB: r = ~ub;
      4'hD: r = (ua >= ub) ? 1 : 0;
      default: r = ua;
    endcase
    e.out = r[7:0];
    e.z = (e.out == 8'h00);
    return e;
  endfunction

  task automatic run_op(input string tag, input logic [3:0] opc, input logic [7:0] a, b,
                        input exp_t e, input int hold, input bit exp_halt);
    int t, lat;
    logic [W-1:0] exp_out;
    t = 0;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    check({tag, " in_ready"}, in_ready, 1);
    exp_q.push_back(e.out);
    in_valid = 1'b1; alu_opc = opc; alu_a = a; alu_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_opc = 4'($urandom); alu_a = 8'($urandom); alu_b = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    exp_out = exp_q.pop_front();
    check({tag, " latency"}, lat, e.lat);
    check({tag, " out"}, alu_out, exp_out);
    check({tag, " hi"}, alu_out_hi, e.hi);
    check({tag, " flags zcvd"}, {flag_z, flag_c, flag_v, flag_dz}, {e.z, e.c, e.v, e.dz});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold valid/ready"}, {out_valid, in_ready}, 2'b10);
      check({tag, " hold out/c"}, {alu_out, flag_c}, {exp_out, e.c});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " post out_valid"}, out_valid, 0);
    check({tag, " post halted/ready"}, {halted, in_ready}, {exp_halt, !exp_halt});
  endtask

  task automatic run16(input string tag, input logic [15:0] a, b, input logic [15:0] exp);
    @(negedge clk);
    in_valid_w = 1'b1; alu_opc_w = 4'hD; alu_a_w = a; alu_b_w = b;
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    check({tag, " valid"}, out_valid_w, 1);
    check({tag, " out"}, alu_out_w, exp);
    @(posedge clk); #1;
    check({tag, " back idle"}, in_ready_w, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    logic [3:0]  r_opc;
    logic [7:0]  r_a, r_b;
    logic [15:0] wa, wb;
    int          swa, swb;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_opc = 4'h0; alu_a = '0; alu_b = '0;
    in_valid_w = 1'b0; out_ready_w = 1'b1; alu_opc_w = 4'h0; alu_a_w = '0; alu_b_w = '0;

    // Directed vectors: opc, a, b, out, hi, c, v, z, dz, latency, hold cycles.
    tbl.push_back(mk(4'h1, 8'hF0, 8'h20, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0));
    tbl.push_back(mk(4'h4, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0, 9, 0));
    tbl.push_back(mk(4'h5, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 9, 0));
    tbl.push_back(mk(4'h5, 8'd5, 8'd0, 8'hFF, 8'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0));
    tbl.push_back(mk(4'h3, 8'd3, 8'd5, 8'hFE, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1, 5));
    tbl.push_back(mk(4'h1, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0));
    tbl.push_back(mk(4'h3, 8'h80, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0));
    tbl.push_back(mk(4'h6, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0));
    tbl.push_back(mk(4'h7, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0));
    tbl.push_back(mk(4'h7, 8'h80, 8'h00, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0));
    tbl.push_back(mk(4'h0, 8'h11, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0));
    tbl.push_back(mk(4'h2, 8'h01, 8'h02, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0));
    tbl.push_back(mk(4'h8, 8'hF0, 8'h0F, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0));
    tbl.push_back(mk(4'h9, 8'hF0, 8'hFF, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0));
    tbl.push_back(mk(4'hA, 8'hAA, 8'hFF, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0));
    tbl.push_back(mk(4'hB, 8'h12, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0));
    tbl.push_back(mk(4'hC, 8'h80, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0));
    tbl.push_back(mk(4'hD, 8'h05, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0));
    tbl.push_back(mk(4'hD, 8'hFF, 8'h05, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 2));
    tbl.push_back(mk(4'hE, 8'h33, 8'h44, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0));
    tbl.push_back(mk(4'h4, 8'h10, 8'h10, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 9, 3));
    tbl.push_back(mk(4'h5, 8'd7, 8'd9, 8'd0, 8'd7, 1'b0, 1'b0, 1'b1, 1'b0, 9, 0));

    #1;
    check("reset in_ready", in_ready, 0);
    check("reset outputs", {out_valid, alu_out, alu_out_hi, flag_z, flag_c, flag_v, flag_dz, halted}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after reset in_ready", in_ready, 1);

    foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i].opc, tbl[i].a, tbl[i].b, tbl[i].e, tbl[i].hold, 1'b0);

    for (int i = 0; i < 150; i++) begin
      r_opc = 4'($urandom_range(0, 14));
      r_a = 8'($urandom);
      r_b = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      run_op($sformatf("rnd%0d op%0h", i, r_opc), r_opc, r_a, r_b, model(r_opc, r_a, r_b),
             $urandom_range(0, 2), 1'b0);
    end

    // Reset in the middle of a multiply discards it and clears every output.
    run_op("pre-reset add", 4'h1, 8'hF0, 8'h20, model(4'h1, 8'hF0, 8'h20), 0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; alu_opc = 4'h4; alu_a = 8'hFF; alu_b = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid-mul reset ready/valid", {in_ready, out_valid}, 2'b00);
    check("mid-mul reset outputs", {alu_out, alu_out_hi, flag_z, flag_c, flag_v, flag_dz, halted}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post-reset add", 4'h1, 8'h01, 8'h01, model(4'h1, 8'h01, 8'h01), 0, 1'b0);

    // HALT retires, then halted sticks and no request is ever accepted.
    run_op("halt", 4'hF, 8'h3C, 8'h00, model(4'hF, 8'h3C, 8'h00), 1, 1'b1);
    in_valid = 1'b1; alu_opc = 4'h1; alu_a = 8'h01; alu_b = 8'h01;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("halted holds", {halted, in_ready, out_valid}, 3'b100);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset clears halted", halted, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready after halt reset", in_ready, 1);

    run16("w16 cmpj ffff>=1", 16'hFFFF, 16'h0001, 16'h0000);
    run16("w16 cmpj 1>=ffff", 16'h0001, 16'hFFFF, 16'h0001);
    run16("w16 cmpj 8000>=7fff", 16'h8000, 16'h7FFF, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      wa = 16'($urandom); wb = 16'($urandom);
      swa = (wa >= 16'h8000) ? int'(wa) - 65536 : int'(wa);
      swb = (wb >= 16'h8000) ? int'(wb) - 65536 : int'(wb);
      run16($sformatf("w16 rnd%0d", i), wa, wb, (swa >= swb) ? 16'h0001 : 16'h0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
